// File: rtl/router_pkg.sv
// Shared defaults and FSM state encoding for the output writer and its lane packer.
package router_pkg;

    localparam int SRAM_DATA_WIDTH_DEF = 64;
    localparam int ADDR_WIDTH_DEF      = 8;
    localparam int ROUTER_COUNT_DEF    = 4;
    localparam int DATA_WIDTH_DEF      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        DONE = 2'd2
    } ow_state_t;

    // Number of router beats that fill one SRAM word.
    function automatic int beats_per_word(input int sram_w, input int rows, input int lane_w);
        return sram_w / (rows * lane_w);
    endfunction

endpackage

// File: rtl/output_word_packer.sv
// Packs router beats into an SRAM word; word/word_done are combinational views of the beat being accepted.
module output_word_packer
    import router_pkg::*;
#(
    parameter int SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
    parameter int ROUTER_COUNT    = ROUTER_COUNT_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF
) (
    input  logic                                     clk,
    input  logic                                     srst,
    input  logic                                     clear,
    input  logic                                     beat_accept,
    input  logic                                     flush,
    input  logic [ROUTER_COUNT-1:0][DATA_WIDTH-1:0]  data,
    output logic                                     word_done,
    output logic [SRAM_DATA_WIDTH-1:0]               word
);

    localparam int BPW    = beats_per_word(SRAM_DATA_WIDTH, ROUTER_COUNT, DATA_WIDTH);
    localparam int BEAT_W = ROUTER_COUNT * DATA_WIDTH;
    localparam int CNT_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SRAM_DATA_WIDTH-1:0] pack_reg;
    logic [CNT_W-1:0]           beat_cnt_reg;
    logic [SRAM_DATA_WIDTH-1:0] word_next;

    // Lanes not yet filled stay zero because pack_reg is cleared after every emitted word.
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_beat
            assign word_next[gi*BEAT_W +: BEAT_W] =
                (beat_accept && beat_cnt_reg == CNT_W'(gi)) ? data : pack_reg[gi*BEAT_W +: BEAT_W];
        end
        if (BPW * BEAT_W < SRAM_DATA_WIDTH) begin : g_pad
            assign word_next[SRAM_DATA_WIDTH-1:BPW*BEAT_W] = '0;
        end
    endgenerate

    assign word      = word_next;
    assign word_done = beat_accept && (beat_cnt_reg == CNT_LAST || flush);

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            pack_reg     <= '0;
            beat_cnt_reg <= '0;
        end else if (word_done) begin
            pack_reg     <= '0;
            beat_cnt_reg <= '0;
        end else if (beat_accept) begin
            pack_reg     <= word_next;
            beat_cnt_reg <= beat_cnt_reg + CNT_ONE;
        end
    end

endmodule

// File: rtl/output_writer.sv
// Streams router beats into consecutive SRAM words between a start and end address, then reports done.
module output_writer
    import router_pkg::*;
#(
    parameter int SRAM_DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int ROUTER_COUNT    = ROUTER_COUNT_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     i_en,
    input  logic                                     i_reg_clear,
    input  logic [ADDR_WIDTH-1:0]                    i_start_addr,
    input  logic [ADDR_WIDTH-1:0]                    i_addr_end,
    input  logic [ROUTER_COUNT-1:0][DATA_WIDTH-1:0]  i_data,
    input  logic                                     i_valid,
    input  logic                                     i_flush,
    output logic                                     o_ready,
    output logic                                     o_sram_write_en,
    output logic [ADDR_WIDTH-1:0]                    o_sram_write_addr,
    output logic [SRAM_DATA_WIDTH-1:0]               o_sram_data,
    output logic                                     o_done,
    output logic [ADDR_WIDTH:0]                      o_word_count
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    ow_state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]      addr_reg;
    logic [ADDR_WIDTH-1:0]      end_reg;
    logic [ADDR_WIDTH:0]        word_count_reg;
    logic                       ready_reg;
    logic                       done_reg;
    logic                       write_en_reg;
    logic [ADDR_WIDTH-1:0]      write_addr_reg;
    logic [SRAM_DATA_WIDTH-1:0] write_data_reg;

    logic                       soft_rst;
    logic                       start;
    logic                       beat_accept;
    logic                       word_done;
    logic [SRAM_DATA_WIDTH-1:0] word;

    assign soft_rst    = i_rst || i_reg_clear;
    assign start       = (state_reg == IDLE || state_reg == DONE) && i_en;
    assign beat_accept = i_valid && ready_reg;

    output_word_packer #(
        .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH),
        .ROUTER_COUNT    (ROUTER_COUNT),
        .DATA_WIDTH      (DATA_WIDTH)
    ) u_packer (
        .clk         (i_clk),
        .srst        (soft_rst),
        .clear       (start),
        .beat_accept (beat_accept),
        .flush       (i_flush),
        .data        (i_data),
        .word_done   (word_done),
        .word        (word)
    );

    always_ff @(posedge i_clk) begin
        if (soft_rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            end_reg        <= '0;
            word_count_reg <= '0;
            ready_reg      <= 1'b0;
            done_reg       <= 1'b0;
            write_en_reg   <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
        end else begin
            write_en_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (i_en) begin
                        addr_reg       <= i_start_addr;
                        end_reg        <= i_addr_end;
                        word_count_reg <= '0;
                        // An empty range completes immediately without touching SRAM.
                        if (i_start_addr > i_addr_end) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= PACK;
                            ready_reg <= 1'b1;
                            done_reg  <= 1'b0;
                        end
                    end
                end
                PACK: begin
                    if (word_done) begin
                        write_en_reg   <= 1'b1;
                        write_addr_reg <= addr_reg;
                        write_data_reg <= word;
                        addr_reg       <= addr_reg + ADDR_ONE;
                        word_count_reg <= word_count_reg + COUNT_ONE;
                        // Terminating on the end address means an end of all-ones never wraps to 0.
                        if (addr_reg == end_reg || i_flush) begin
                            state_reg <= DONE;
                            ready_reg <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready           = ready_reg;
    assign o_done            = done_reg;
    assign o_word_count      = word_count_reg;
    assign o_sram_write_en   = write_en_reg;
    assign o_sram_write_addr = write_addr_reg;
    assign o_sram_data       = write_data_reg;

endmodule

// File: tb/tb_output_writer.sv
// Directed bench for output_writer: hand-computed SRAM writes, counts and handshake levels.
module tb_output_writer;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_en;
    logic             i_reg_clear;
    logic [7:0]       i_start_addr;
    logic [7:0]       i_addr_end;
    logic [3:0][7:0]  i_data;
    logic             i_valid;
    logic             i_flush;
    logic             o_ready;
    logic             o_sram_write_en;
    logic [7:0]       o_sram_write_addr;
    logic [63:0]      o_sram_data;
    logic             o_done;
    logic [8:0]       o_word_count;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [7:0]  wr_addr_q[$];
    logic [63:0] wr_data_q[$];

    always #5 i_clk = ~i_clk;

    output_writer dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_en              (i_en),
        .i_reg_clear       (i_reg_clear),
        .i_start_addr      (i_start_addr),
        .i_addr_end        (i_addr_end),
        .i_data            (i_data),
        .i_valid           (i_valid),
        .i_flush           (i_flush),
        .o_ready           (o_ready),
        .o_sram_write_en   (o_sram_write_en),
        .o_sram_write_addr (o_sram_write_addr),
        .o_sram_data       (o_sram_data),
        .o_done            (o_done),
        .o_word_count      (o_word_count)
    );

    always @(negedge i_clk) begin
        if (o_sram_write_en) begin
            wr_addr_q.push_back(o_sram_write_addr);
            wr_data_q.push_back(o_sram_data);
            $display("write addr=%02h data=%016h count=%0d", o_sram_write_addr, o_sram_data, o_word_count);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // All stimulus tasks are entered and left on a falling edge.
    task automatic start_xfer(input logic [7:0] s, input logic [7:0] e);
        i_start_addr = s;
        i_addr_end   = e;
        i_en         = 1'b1;
        @(negedge i_clk);
        i_en = 1'b0;
    endtask

    task automatic do_beat(input logic [31:0] d, input logic fl);
        i_data  = d;
        i_valid = 1'b1;
        i_flush = fl;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge i_clk);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_write(input string tag, input int idx, input logic [7:0] a, input logic [63:0] d);
        if (idx < wr_addr_q.size()) begin
            check({tag, "_addr"}, {56'd0, wr_addr_q[idx]}, {56'd0, a});
            check({tag, "_data"}, wr_data_q[idx], d);
        end else begin
            check({tag, "_missing"}, 64'(wr_addr_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_en = 1'b0; i_reg_clear = 1'b0;
        i_start_addr = '0; i_addr_end = '0; i_data = '0; i_valid = 1'b0; i_flush = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;

        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_wen", 64'(o_sram_write_en), 64'd0);
        check("rst_count", 64'(o_word_count), 64'd0);
        check("rst_addr", 64'(o_sram_write_addr), 64'd0);
        check("rst_data", o_sram_data, 64'd0);

        // Two full words, terminating on the end address
        clear_log();
        start_xfer(8'h10, 8'h11);
        check("t1_ready", 64'(o_ready), 64'd1);
        do_beat(32'h03020100, 1'b0);
        do_beat(32'h07060504, 1'b0);
        do_beat(32'h0B0A0908, 1'b0);
        do_beat(32'h0F0E0D0C, 1'b0);
        settle();
        check("t1_nwr", 64'(wr_addr_q.size()), 64'd2);
        check_write("t1_w0", 0, 8'h10, 64'h0706050403020100);
        check_write("t1_w1", 1, 8'h11, 64'h0F0E0D0C0B0A0908);
        check("t1_done", 64'(o_done), 64'd1);
        check("t1_count", 64'(o_word_count), 64'd2);
        check("t1_ready_off", 64'(o_ready), 64'd0);

        // Flush on an incomplete word zero-fills the upper lanes
        clear_log();
        start_xfer(8'h20, 8'h2F);
        check("t2_done_clr", 64'(o_done), 64'd0);
        do_beat(32'h13121110, 1'b0);
        do_beat(32'h17161514, 1'b0);
        do_beat(32'h1B1A1918, 1'b1);
        settle();
        check("t2_nwr", 64'(wr_addr_q.size()), 64'd2);
        check_write("t2_w0", 0, 8'h20, 64'h1716151413121110);
        check_write("t2_w1", 1, 8'h21, 64'h000000001B1A1918);
        check("t2_done", 64'(o_done), 64'd1);
        check("t2_count", 64'(o_word_count), 64'd2);

        // Empty range
        clear_log();
        start_xfer(8'h05, 8'h04);
        check("t3_done", 64'(o_done), 64'd1);
        check("t3_ready", 64'(o_ready), 64'd0);
        do_beat(32'hDEADBEEF, 1'b0);
        settle();
        check("t3_nwr", 64'(wr_addr_q.size()), 64'd0);
        check("t3_count", 64'(o_word_count), 64'd0);

        // Reset mid-word discards the partial beat
        clear_log();
        start_xfer(8'h30, 8'h31);
        do_beat(32'hAAAAAAAA, 1'b0);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("t4_ready", 64'(o_ready), 64'd0);
        check("t4_done", 64'(o_done), 64'd0);
        check("t4_count", 64'(o_word_count), 64'd0);
        check("t4_data", o_sram_data, 64'd0);
        start_xfer(8'h30, 8'h31);
        do_beat(32'h44332211, 1'b0);
        do_beat(32'h88776655, 1'b0);
        settle();
        check("t4_nwr", 64'(wr_addr_q.size()), 64'd1);
        check_write("t4_w0", 0, 8'h30, 64'h8877665544332211);
        check("t4_count1", 64'(o_word_count), 64'd1);
        check("t4_ready_on", 64'(o_ready), 64'd1);
        i_reg_clear = 1'b1;
        @(negedge i_clk);
        i_reg_clear = 1'b0;
        check("t4_clr_ready", 64'(o_ready), 64'd0);
        check("t4_clr_count", 64'(o_word_count), 64'd0);

        // End address all-ones: one write, later beats dropped, no wrap
        clear_log();
        start_xfer(8'hFF, 8'hFF);
        do_beat(32'hA3A2A1A0, 1'b0);
        do_beat(32'hA7A6A5A4, 1'b0);
        check("t5_ready_off", 64'(o_ready), 64'd0);
        do_beat(32'hABAAA9A8, 1'b0);
        do_beat(32'hAFAEADAC, 1'b0);
        settle();
        check("t5_nwr", 64'(wr_addr_q.size()), 64'd1);
        check_write("t5_w0", 0, 8'hFF, 64'hA7A6A5A4A3A2A1A0);
        check("t5_done", 64'(o_done), 64'd1);
        check("t5_count", 64'(o_word_count), 64'd1);

        // i_en inside PACK and beats inside DONE are ignored
        clear_log();
        start_xfer(8'h40, 8'h43);
        do_beat(32'hB3B2B1B0, 1'b0);
        do_beat(32'hB7B6B5B4, 1'b0);
        start_xfer(8'h60, 8'h70);
        check("t6_ready_hold", 64'(o_ready), 64'd1);
        do_beat(32'hBBBAB9B8, 1'b0);
        do_beat(32'hBFBEBDBC, 1'b0);
        do_beat(32'hC3C2C1C0, 1'b1);
        do_beat(32'hEEEEEEEE, 1'b0);
        do_beat(32'hFFFFFFFF, 1'b0);
        settle();
        check("t6_nwr", 64'(wr_addr_q.size()), 64'd3);
        check_write("t6_w0", 0, 8'h40, 64'hB7B6B5B4B3B2B1B0);
        check_write("t6_w1", 1, 8'h41, 64'hBFBEBDBCBBBAB9B8);
        check_write("t6_w2", 2, 8'h42, 64'h00000000C3C2C1C0);
        check("t6_count", 64'(o_word_count), 64'd3);
        check("t6_done", 64'(o_done), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/output_writer.md
OUTPUT_WRITER -- requirements
Module: output_writer

Interface
REQ-001 SHALL have parameter SRAM_DATA_WIDTH, default 64, meaning output SRAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning SRAM address width.
REQ-003 SHALL have parameter ROUTER_COUNT, default 4, meaning number of PE rows delivering one lane each per beat.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, meaning lane width in bits; BEATS_PER_WORD = SRAM_DATA_WIDTH/(ROUTER_COUNT*DATA_WIDTH), default 2.
REQ-005 SHALL have ports: i_clk  in  1  sole clock; i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: i_en  in  1  start transfer; i_reg_clear  in  1  synchronous soft clear.
REQ-007 SHALL have ports: i_start_addr, i_addr_end  in  ADDR_WIDTH  first/last SRAM word address, inclusive.
REQ-008 SHALL have ports: i_data  in  [ROUTER_COUNT][DATA_WIDTH]  one lane per row; i_valid  in  1  beat valid; i_flush  in  1  marks last beat.
REQ-009 SHALL have ports: o_ready  out  1  beat accepted when i_valid && o_ready.
REQ-010 SHALL have ports: o_sram_write_en  out  1; o_sram_write_addr  out  ADDR_WIDTH; o_sram_data  out  SRAM_DATA_WIDTH.
REQ-011 SHALL have ports: o_done  out  1  transfer complete; o_word_count  out  ADDR_WIDTH+1  words written this transfer.

Function
REQ-012 SHALL implement FSM states IDLE, PACK, DONE; reset state IDLE.
REQ-013 SHALL, in IDLE or DONE on i_en, latch i_start_addr/i_addr_end, clear beat counter, o_word_count and o_done, and enter PACK; if i_start_addr > i_addr_end, enter DONE instead with no writes.
REQ-014 SHALL ignore i_en while in PACK.
REQ-015 SHALL drive o_ready = 1 only in PACK; no back-pressure within PACK.
REQ-016 SHALL place row r of beat k at bits [(k*ROUTER_COUNT+r)*DATA_WIDTH +: DATA_WIDTH] of the word.
REQ-017 SHALL, on the accepted beat with beat counter = BEATS_PER_WORD-1, pulse o_sram_write_en for exactly one cycle on the next clock, with o_sram_write_addr = current address and o_sram_data = packed word (registered outputs, latency 1).
REQ-018 SHALL increment the write address and o_word_count in the same cycle as each write pulse; beat counter wraps to 0.
REQ-019 SHALL, on accepted beat with i_flush = 1 and incomplete word, write the partial word next cycle with unfilled lanes zero.
REQ-020 SHALL enter DONE in the cycle of the write pulse whose address equals i_addr_end, or of any flush write; o_ready deasserts in that same cycle.
REQ-021 SHALL hold o_done = 1 throughout DONE; o_sram_write_en = 0 outside write pulses.
REQ-022 SHALL treat beats presented when o_ready = 0 as dropped with no state change.
REQ-023 SHALL compute address increment at ADDR_WIDTH without overflow beyond i_addr_end (i_addr_end = 2^ADDR_WIDTH-1 terminates, no wrap write).

Reset
REQ-024 SHALL, on i_rst or i_reg_clear, force state IDLE, all outputs 0, counters and pack register 0, next clock.
REQ-025 SHALL discard any partial word on reset/clear mid-PACK with no write pulse; i_rst and i_reg_clear take priority over i_en and beats in the same cycle.

Structure
REQ-026 SHALL take SRAM_DATA_WIDTH, ADDR_WIDTH, ROUTER_COUNT, DATA_WIDTH defaults and the FSM state enum from shared package router_pkg.
REQ-027 SHALL isolate lane packing (beat counter, pack register, zero fill) in sub-module output_word_packer; FSM and addressing stay in output_writer.

Verification
REQ-028 SHALL cover: start=0x10, end=0x11, beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C -> writes 0x0706050403020100@0x10, 0x0F0E0D0C0B0A0908@0x11, o_done, o_word_count=2.
REQ-029 SHALL cover: start=0x20, end=0x2F, 3 beats, third with i_flush -> 2 writes, second = 0x00000000_<beat3>@0x21, DONE, count=2.
REQ-030 SHALL cover: start=0x05, end=0x04 -> DONE next cycle, no write pulses, count=0.
REQ-031 SHALL cover: i_rst after 1 beat of word -> no write, IDLE, outputs 0; re-issue i_en -> fresh packing from beat 0.
REQ-032 SHALL cover: start=end=0xFF, 4 valid beats -> single write@0xFF, o_ready low after it, beats 3-4 dropped, no address wrap.
REQ-033 SHALL cover: i_en asserted mid-PACK and i_valid in DONE -> both ignored; addresses and count unchanged.
